// File: rtl/dmem_pkg.sv
// Shared types, size encodings and default memory window for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0]  SZ_BYTE        = 2'd0;
  localparam logic [1:0]  SZ_HALF        = 2'd1;
  localparam logic [1:0]  SZ_WORD        = 2'd2;
  localparam logic [1:0]  SZ_ILLEGAL     = 2'd3;
  localparam logic [31:0] DEF_START_ADDR = 32'h0100_0000;
  localparam int unsigned DEF_MEM_BYTES  = 32'd1428;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load data extension: selects byte/half/word from the LSB-aligned memory word and
// sign- or zero-extends it; misaligned or illegal sizes yield zero.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  // Extend according to size and signedness.
  always_comb begin
    o_data = 32'd0;
    case (i_size)
      SZ_BYTE: begin
        if (i_unsigned) o_data = {24'd0, i_word[7:0]};
        else            o_data = {{24{i_word[7]}}, i_word[7:0]};
      end
      SZ_HALF: begin
        if (i_addr_lo[0])    o_data = 32'd0;
        else if (i_unsigned) o_data = {16'd0, i_word[15:0]};
        else                 o_data = {{16{i_word[15]}}, i_word[15:0]};
      end
      SZ_WORD: begin
        if (i_addr_lo == 2'd0) o_data = i_word;
        else                   o_data = 32'd0;
      end
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (pipeline) normally wins, port 1 (debug/loader)
// is forced through after STARVE_LIMIT consecutive losses; one request per 3 cycles.
module dmem_arbiter #(
  parameter logic [31:0] START_ADDR   = dmem_pkg::DEF_START_ADDR,
  parameter int unsigned MEM_BYTES    = dmem_pkg::DEF_MEM_BYTES,
  parameter int unsigned STARVE_LIMIT = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  import dmem_pkg::*;

  localparam int unsigned       LP_SW    = $clog2(STARVE_LIMIT + 32'd1);
  localparam logic [LP_SW-1:0]  LP_LIMIT = LP_SW'(STARVE_LIMIT);
  localparam logic [32:0]       LP_LO    = {1'b0, START_ADDR};
  localparam logic [32:0]       LP_END   = {1'b0, START_ADDR} + 33'(MEM_BYTES);

  state_t            r_state, w_next_state;
  logic [LP_SW-1:0]  r_starve;
  logic              r_port, r_we, r_uns;
  logic [1:0]        r_size;
  logic [31:0]       r_addr, r_wdata, r_rdata;
  logic              w_grant0, w_grant1, w_acc0, w_acc1, w_accept, w_idle, w_resp, w_err;
  logic [32:0]       w_end;
  logic [31:0]       w_ext;

  // Arbitration and handshake; nothing is accepted while reset is held.
  always_comb begin
    w_grant1   = req1_valid & (~req0_valid | (r_starve == LP_LIMIT));
    w_grant0   = req0_valid & ~w_grant1;
    w_idle     = (r_state == ST_IDLE) & ~reset;
    req0_ready = w_idle & w_grant0;
    req1_ready = w_idle & w_grant1;
    w_acc0     = req0_valid & req0_ready;
    w_acc1     = req1_valid & req1_ready;
    w_accept   = w_acc0 | w_acc1;
  end

  // Error classification from the latched request.
  always_comb begin
    w_end = {1'b0, r_addr} + {30'd0, size_bytes(r_size)};
    w_err = (r_size == SZ_ILLEGAL) | misaligned(r_size, r_addr[1:0]) |
            ({1'b0, r_addr} < LP_LO) | (w_end > LP_END);
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_ACCESS;
        else          w_next_state = ST_IDLE;
      end
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Starvation counter: counts port-1 losses in IDLE, saturating, cleared on port-1 accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_acc1) begin
      r_starve <= '0;
    end else if (w_idle && req1_valid && (r_starve != LP_LIMIT)) begin
      r_starve <= r_starve + LP_SW'(1);
    end else begin
      r_starve <= r_starve;
    end
  end

  // Request latch on accept and load-data capture at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_port  <= w_acc1;
      r_we    <= w_acc1 ? req1_we       : req0_we;
      r_uns   <= w_acc1 ? req1_unsigned : req0_unsigned;
      r_size  <= w_acc1 ? req1_size     : req0_size;
      r_addr  <= w_acc1 ? req1_addr     : req0_addr;
      r_wdata <= w_acc1 ? req1_wdata    : req0_wdata;
      r_rdata <= 32'd0;
    end else if (r_state == ST_ACCESS) begin
      r_rdata <= (~r_we & ~w_err) ? w_ext : 32'd0;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  dmem_load_ext u_load_ext (
    .i_word     (mem_data_out),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_addr_lo  (r_addr[1:0]),
    .o_data     (w_ext)
  );

  // Memory side is not gated by reset so a store caught by reset in ACCESS still lands.
  always_comb begin
    if (r_state == ST_ACCESS) begin
      mem_address     = r_addr;
      mem_access_size = r_size;
      mem_data_in     = r_wdata;
      mem_read_write  = r_we & ~w_err;
    end else begin
      mem_address     = 32'd0;
      mem_access_size = 2'd0;
      mem_data_in     = 32'd0;
      mem_read_write  = 1'b0;
    end
  end

  // Response pulse on the accepted port only; data and error are zero outside the pulse.
  always_comb begin
    w_resp      = (r_state == ST_RESP) & ~reset;
    resp0_valid = w_resp & ~r_port;
    resp1_valid = w_resp & r_port;
    resp0_rdata = resp0_valid ? r_rdata : 32'd0;
    resp1_rdata = resp1_valid ? r_rdata : 32'd0;
    resp0_err   = resp0_valid & w_err;
    resp1_err   = resp1_valid & w_err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array memory model behind the memory port.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam logic [31:0] START = 32'h0100_0000;
  localparam int          MB    = 1428;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eer;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, req0_unsigned;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we, req1_unsigned;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;

  logic [7:0]  mem [0:MB-1];
  exp_t        sb[$];
  int          grants[$];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          wr_cycles = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.START_ADDR(START), .MEM_BYTES(MB), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_size(req0_size), .req0_unsigned(req0_unsigned), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_unsigned(req1_unsigned), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_access_size(mem_access_size), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int moff(input logic [31:0] a, input int i);
    logic [32:0] t;
    t = {1'b0, a} + 33'(i) - {1'b0, START};
    return (t < 33'(MB)) ? int'(t[10:0]) : MB;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (moff(a, i) < MB) w[8*i +: 8] = mem[moff(a, i)];
    end
    return w;
  endfunction

  always_comb mem_data_out = rd_word(mem_address);

  // Memory model write port.
  always @(posedge clk) begin
    if (mem_read_write) begin
      for (int i = 0; i < 4; i++) begin
        if (i < ((mem_access_size == 2'd0) ? 1 : (mem_access_size == 2'd1) ? 2 : 4))
          if (moff(mem_address, i) < MB) mem[moff(mem_address, i)] <= mem_data_in[8*i +: 8];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push on accept, pop and compare on response.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] rd;
    logic        er;
    if (mem_read_write) wr_cycles++;
    if (req0_valid && req0_ready) begin
      sb.push_back('{0, exp_rd[0], exp_er[0], cyc});
      grants.push_back(0);
    end
    if (req1_valid && req1_ready) begin
      sb.push_back('{1, exp_rd[1], exp_er[1], cyc});
      grants.push_back(1);
    end
    if (!resp0_valid) chk("idle_zero0", {resp0_rdata[31:1], resp0_rdata[0] | resp0_err}, 32'd0);
    if (!resp1_valid) chk("idle_zero1", {resp1_rdata[31:1], resp1_rdata[0] | resp1_err}, 32'd0);
    if (resp0_valid || resp1_valid) begin
      chk("resp_both", 32'(resp0_valid & resp1_valid), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e  = sb.pop_front();
        rd = resp1_valid ? resp1_rdata : resp0_rdata;
        er = resp1_valid ? resp1_err : resp0_err;
        chk("resp_port", 32'(resp1_valid), 32'(e.port));
        chk("resp_rdata", rd, e.rdata);
        chk("resp_err", 32'(er), 32'(e.err));
        chk("resp_latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
  end

  task automatic drive(input vec_t v, input logic valid);
    exp_rd[v.port] = v.erd;
    exp_er[v.port] = v.eer;
    if (v.port) begin
      req1_we = v.we; req1_size = v.size; req1_unsigned = v.uns;
      req1_addr = v.addr; req1_wdata = v.wdata; req1_valid = valid;
    end else begin
      req0_we = v.we; req0_size = v.size; req0_unsigned = v.uns;
      req0_addr = v.addr; req0_wdata = v.wdata; req0_valid = valid;
    end
  endtask

  task automatic issue(input vec_t v);
    bit done;
    done = 1'b0;
    drive(v, 1'b1);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (v.port ? req1_ready : req0_ready) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (v.port) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    vec_t v;
    int   exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    mem[3] <= 8'h80;
    reset = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_size = 2'd0; req0_unsigned = 1'b0;
    req0_addr = START; req0_wdata = 32'd0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_size = 2'd0; req1_unsigned = 1'b0;
    req1_addr = 32'd0; req1_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_resp", 32'(resp0_valid | resp1_valid), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_ctl", {mem_data_in[31:3], mem_read_write, mem_access_size}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Signed byte load from port 0.
    issue('{1'b0, 1'b0, SZ_BYTE, 1'b0, START + 32'd3, 32'd0, 32'hFFFF_FF80, 1'b0});
    drain();

    // Port 1 store then load of the same word.
    wr_cycles = 0;
    issue('{1'b1, 1'b1, SZ_WORD, 1'b0, START + 32'd16, 32'hDEAD_BEEF, 32'd0, 1'b0});
    drain();
    chk("store_wr_cycles", 32'(wr_cycles), 32'd1);
    issue('{1'b1, 1'b0, SZ_WORD, 1'b0, START + 32'd16, 32'd0, 32'hDEAD_BEEF, 1'b0});
    drain();

    // Extension variants and window/alignment boundaries.
    tv.push_back('{1'b0, 1'b0, SZ_HALF,    1'b0, START + 32'd18,   32'd0, 32'hFFFF_DEAD, 1'b0});
    tv.push_back('{1'b1, 1'b0, SZ_BYTE,    1'b1, START + 32'd19,   32'd0, 32'h0000_00DE, 1'b0});
    tv.push_back('{1'b0, 1'b0, SZ_HALF,    1'b1, START + 32'd16,   32'd0, 32'h0000_BEEF, 1'b0});
    tv.push_back('{1'b1, 1'b0, SZ_BYTE,    1'b0, START + 32'd16,   32'd0, 32'hFFFF_FFEF, 1'b0});
    tv.push_back('{1'b0, 1'b0, SZ_WORD,    1'b0, START + 32'd1424, 32'd0, 32'd0, 1'b0});
    tv.push_back('{1'b0, 1'b0, SZ_HALF,    1'b0, START + 32'd1426, 32'd0, 32'd0, 1'b0});
    tv.push_back('{1'b0, 1'b0, SZ_BYTE,    1'b0, START + 32'd1427, 32'd0, 32'd0, 1'b0});
    tv.push_back('{1'b0, 1'b0, SZ_WORD,    1'b0, START + 32'd1428, 32'd0, 32'd0, 1'b1});
    tv.push_back('{1'b1, 1'b0, SZ_BYTE,    1'b0, START + 32'd1428, 32'd0, 32'd0, 1'b1});
    tv.push_back('{1'b0, 1'b0, SZ_BYTE,    1'b0, START - 32'd1,    32'd0, 32'd0, 1'b1});
    tv.push_back('{1'b0, 1'b0, SZ_ILLEGAL, 1'b0, START,            32'd0, 32'd0, 1'b1});
    tv.push_back('{1'b1, 1'b0, SZ_HALF,    1'b0, START + 32'd1,    32'd0, 32'd0, 1'b1});
    foreach (tv[i]) begin
      issue(tv[i]);
      drain();
    end

    // Error requests must never write memory.
    wr_cycles = 0;
    issue('{1'b0, 1'b1, SZ_WORD, 1'b0, START + 32'd2, 32'hDEAD_BEEF, 32'd0, 1'b1});
    drain();
    issue('{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h00FF_FFFF, 32'd0, 32'd0, 1'b1});
    drain();
    chk("err_wr_cycles", 32'(wr_cycles), 32'd0);
    chk("err_mem_intact", rd_word(START), 32'h8000_0000);

    // Both ports continuously valid: starvation forces every 5th grant to port 1.
    grants.delete();
    drive('{1'b0, 1'b0, SZ_WORD, 1'b0, START + 32'd16, 32'd0, 32'hDEAD_BEEF, 1'b0}, 1'b1);
    drive('{1'b1, 1'b0, SZ_HALF, 1'b1, START + 32'd16, 32'd0, 32'h0000_BEEF, 1'b0}, 1'b1);
    for (int i = 0; i < 200 && grants.size() < 10; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    chk("grant_count", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < grants.size()) chk("grant_order", 32'(grants[i]), 32'(exp_order[i]));

    // Reset caught in ACCESS of a store: write lands, no response, ready right after.
    v = '{1'b1, 1'b1, SZ_WORD, 1'b0, START + 32'd32, 32'h1234_5678, 32'd0, 1'b0};
    drive(v, 1'b1);
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (req1_ready) done = 1'b1;
      end
      if (!done) chk("rst_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    reset = 1'b1;
    drive('{1'b0, 1'b0, SZ_WORD, 1'b0, START + 32'd32, 32'd0, 32'h1234_5678, 1'b0}, 1'b1);
    @(negedge clk);
    chk("ready_in_reset", 32'(req0_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req0_ready), 32'd1);
    chk("rst_store_mem", rd_word(START + 32'd32), 32'h1234_5678);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: START_ADDR, default 32'h01000000, base byte address of data memory; MEM_BYTES, default 1428, memory size in bytes; STARVE_LIMIT, default 4, consecutive losses before port 1 is forced to win.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have these ports (port n in {0,1}; port 0 = pipeline MEM stage, port 1 = debug/loader):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous active-high reset
- reqn_valid  in  1  request present
- reqn_ready  out  1  request accepted this cycle
- reqn_we  in  1  1=store, 0=load
- reqn_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- reqn_unsigned  in  1  load zero-extends when 1
- reqn_addr  in  32  byte address
- reqn_wdata  in  32  store data, LSB-aligned
- respn_valid  out  1  one-cycle response pulse
- respn_rdata  out  32  extended load data (0 for stores and errors)
- respn_err  out  1  request rejected
- mem_address  out  32  to memory
- mem_read_write  out  1  1=write
- mem_access_size  out  2  to memory
- mem_data_in  out  32  store data to memory
- mem_data_out  in  32  combinational little-endian word read at mem_address

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS and RESP; IDLE->ACCESS on accept; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-005 SHALL assert reqn_ready only in IDLE and only for the arbitration winner; accept = valid & ready.
REQ-006 SHALL grant port 0 when both ports are valid, unless the starvation counter equals STARVE_LIMIT, in which case port 1 SHALL win.
REQ-007 SHALL increment the starvation counter when port 1 is valid and loses in IDLE, clear it when port 1 is accepted, and saturate it at STARVE_LIMIT.
REQ-008 SHALL register the address, size, we, wdata, unsigned flag and port id on accept; request inputs SHALL be ignored after accept.
REQ-009 SHALL flag an error when size==3, when size==1 and addr[0]!=0, when size==2 and addr[1:0]!=0, or when the access does not lie entirely within [START_ADDR, START_ADDR+MEM_BYTES).
REQ-010 SHALL drive mem_read_write=1 only in ACCESS, only for a non-error store, and 0 in every other cycle.
REQ-011 SHALL drive mem_address, mem_access_size and mem_data_in from the latched request in ACCESS, and 0 otherwise.
REQ-012 SHALL, for a non-error load, capture mem_data_out at the end of ACCESS, extended per latched size/unsigned: byte=[7:0], half=[15:0], word unchanged.
REQ-013 SHALL pulse respn_valid for exactly one cycle in RESP on the accepted port only; latency is accept at cycle N, response at N+2; throughput is one request per 3 cycles.
REQ-014 SHALL hold respn_rdata and respn_err at 0 when respn_valid is 0.
REQ-015 SHALL NOT perform a memory write for any error request; such a request still completes with respn_err=1 at N+2.

Reset
REQ-016 SHALL, while reset=1, force state=IDLE, starvation counter=0, all ready/resp outputs=0, all mem_* outputs=0 and the latched request=0.
REQ-017 SHALL treat reset sampled in ACCESS as follows: the store write on that edge completes, no response is issued, and the FSM is in IDLE next cycle.
REQ-018 SHALL treat reset sampled in RESP as follows: the response pulse is cut off and no request is accepted during reset.

Structure
REQ-019 SHALL take its state enum, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and default START_ADDR/MEM_BYTES from shared package dmem_pkg.
REQ-020 SHALL place load extension in a single combinational sub-module dmem_load_ext (inputs: word, size, unsigned flag, addr[1:0]; output: 32-bit extended data).

Verification
REQ-021 SHALL cover a port 0 load: size=0, unsigned=0, addr 32'h01000003, memory byte 8'h80 -> resp0_valid at N+2, rdata=32'hFFFFFF80, err=0.
REQ-022 SHALL cover a port 1 store then load: word 32'hDEADBEEF to 32'h01000010, then word load of the same address -> rdata=32'hDEADBEEF; mem_read_write high for exactly one cycle.
REQ-023 SHALL cover both ports continuously valid -> port 0 wins 4 grants, the 5th grant goes to port 1, then the starvation counter is 0.
REQ-024 SHALL cover a misaligned word store at 32'h01000002 and a half load at 32'h00FFFFFF -> err=1, rdata=0, mem_read_write never asserted.
REQ-025 SHALL cover reset asserted in ACCESS of a store of 32'h12345678 -> memory holds the value, no resp pulse, ready asserts the cycle after reset deasserts.
